// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Write-back end of the EX->MEM->WB result path. The MEM-stage write request
//   is captured in a MEM/WB pipeline register, committed to a general register
//   file, and the register file is read by the ID stage through two ports.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   : a read that hits the entry currently sitting in WB returns
//                 wb_wdata (write-through), so ID sees the committing value in
//                 the same cycle.
//     undefined : reads return the stored register only; the written value
//                 becomes visible the cycle after commit.
//
// Ports
//   clk, rst             clock (posedge) and synchronous active-high reset
//   mem_wd/wdata/wreg    write request from the MEM stage
//   stall                hold the MEM/WB register
//   flush                replace the MEM/WB register with a NOP (beats stall)
//   re1/raddr1/rdata1    read port 1 (combinational data)
//   re2/raddr2/rdata2    read port 2 (combinational data)
//   wb_wd/wdata/wreg     registered MEM/WB contents
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wreg,
    input  logic              stall,
    input  logic              flush,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [ADDR_W-1:0] wb_wd,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_wreg
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // A commit is only meaningful for a valid write that does not target r0.
    logic commit;
    assign commit = wb_wreg && (wb_wd != '0);

    // MEM/WB pipeline register: rst > flush > stall > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wd    <= '0;
            wb_wdata <= '0;
            wb_wreg  <= 1'b0;
        end else if (flush) begin
            wb_wd    <= '0;
            wb_wdata <= '0;
            wb_wreg  <= 1'b0;
        end else if (!stall) begin
            wb_wd    <= mem_wd;
            wb_wdata <= mem_wdata;
            wb_wreg  <= mem_wreg;
        end
    end

    // Register file commit. It uses the pre-edge WB contents and is not gated
    // by stall: a held entry simply rewrites the same value. The reset edge
    // discards whatever was pending in WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wb_wd] <= wb_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic              re,
                                                    input logic [ADDR_W-1:0] raddr);
        logic [DATA_W-1:0] value;
        value = '0;
        if (rst || !re || (raddr == '0)) begin
            value = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (wb_wreg && (wb_wd == raddr)) begin
            value = wb_wdata;
`endif
        end else begin
            value = regs[raddr];
        end
        return value;
    endfunction

    always_comb begin
        rdata1 = read_port(re1, raddr1);
    end

    always_comb begin
        rdata2 = read_port(re2, raddr2);
    end

endmodule
